// File: rtl/botoes_condicionador.sv
// botoes_condicionador: conditions three raw push-buttons (carga, j1, j2).
// Each button passes through a 2-flop synchronizer and its own debounce FSM.
// Every accepted press becomes a one-clock pulse on carga_int, j1_int or j2_int.
//
// Output protocol: there is no valid/ready handshake.
//   - Each *_int output is a registered strobe, high for exactly one clock per
//     accepted press.
//   - At most one strobe is high in any cycle.
//   - btn_nivel carries the debounced levels {carga, j2, j1}.
//
// Optional feature: define BOTOES_TURN_LOCKOUT_EN to enable a turn token.
//   - With the token, the same player cannot pulse twice in a row unless the
//     other player or carga pulses in between.
module botoes_condicionador #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_carga,
  input  logic       btn_j1,
  input  logic       btn_j2,
  output logic       carga_int,
  output logic       j1_int,
  output logic       j2_int,
  output logic [2:0] btn_nivel
);

  // Counter wide enough to hold DEBOUNCE_CYCLES; it saturates instead of wrapping.
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = (DEBOUNCE_CYCLES < 1) ? '0 : CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  // Channel index: 0 = j1, 1 = j2, 2 = carga (same order as btn_nivel).
  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    CONF_PRESS  = 2'd1,
    PRESSIONADO = 2'd2,
    CONF_SOLTO  = 2'd3
  } estado_t;

  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  estado_t       estado [3];   // per-channel FSM state, observable hierarchically
  logic [CW-1:0] cont   [3];
  logic [2:0]    nivel;
  logic [2:0]    cand;         // registered press candidates, one clock wide

  logic sel_carga;
  logic sel_j1;
  logic sel_j2;
  logic lib_j1;
  logic lib_j2;

  assign raw       = {btn_carga, btn_j2, btn_j1};
  assign btn_nivel = nivel;

  // Two-flop synchronizer on every raw button before any other logic.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Independent debounce FSM per channel.
  // - A confirm state must see the new level for DEBOUNCE_CYCLES further clocks.
  // - One contrary sample returns the channel to its previous stable state.
  // - Only the entry into PRESSIONADO raises a press candidate.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        estado[i] <= SOLTO;
        cont[i]   <= '0;
      end
      nivel <= '0;
      cand  <= '0;
    end else begin
      cand <= '0;
      for (int i = 0; i < 3; i++) begin
        case (estado[i])
          SOLTO: begin
            if (sync2[i]) begin
              estado[i] <= CONF_PRESS;
              cont[i]   <= '0;
            end
          end
          CONF_PRESS: begin
            if (!sync2[i]) begin
              estado[i] <= SOLTO;
              cont[i]   <= '0;
            end else if (cont[i] >= CNT_LAST) begin
              estado[i] <= PRESSIONADO;
              cont[i]   <= '0;
              nivel[i]  <= 1'b1;
              cand[i]   <= 1'b1;
            end else if (cont[i] != CNT_MAX) begin
              cont[i] <= cont[i] + 1'b1;
            end
          end
          PRESSIONADO: begin
            if (!sync2[i]) begin
              estado[i] <= CONF_SOLTO;
              cont[i]   <= '0;
            end
          end
          CONF_SOLTO: begin
            if (sync2[i]) begin
              estado[i] <= PRESSIONADO;
              cont[i]   <= '0;
            end else if (cont[i] >= CNT_LAST) begin
              estado[i] <= SOLTO;
              cont[i]   <= '0;
              nivel[i]  <= 1'b0;
            end else if (cont[i] != CNT_MAX) begin
              cont[i] <= cont[i] + 1'b1;
            end
          end
          default: begin
            estado[i] <= SOLTO;
            cont[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Fixed-priority arbitration: carga beats j1, j1 beats j2; losers are dropped.
  always_comb begin
    sel_carga = cand[2];
    sel_j1    = cand[0] & ~cand[2];
    sel_j2    = cand[1] & ~cand[2] & ~cand[0];
  end

`ifdef BOTOES_TURN_LOCKOUT_EN
  // VEZ_J1 means j1 pulsed last, so j1 is blocked; VEZ_J2 is the mirror case.
  typedef enum logic [1:0] {
    VEZ_LIVRE = 2'd0,
    VEZ_J1    = 2'd1,
    VEZ_J2    = 2'd2
  } vez_t;

  vez_t vez;

  // A player may pulse only when the token does not name that player.
  always_comb begin
    lib_j1 = (vez != VEZ_J1);
    lib_j2 = (vez != VEZ_J2);
  end

  // Token follows the pulse actually issued; carga frees both players.
  always_ff @(posedge clock) begin
    if (reset) begin
      vez <= VEZ_LIVRE;
    end else if (sel_carga) begin
      vez <= VEZ_LIVRE;
    end else if (sel_j1 && lib_j1) begin
      vez <= VEZ_J1;
    end else if (sel_j2 && lib_j2) begin
      vez <= VEZ_J2;
    end
  end
`else
  // Without the token every arbitrated candidate is issued.
  always_comb begin
    lib_j1 = 1'b1;
    lib_j2 = 1'b1;
  end
`endif

  // Registered one-clock output strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      carga_int <= 1'b0;
      j1_int    <= 1'b0;
      j2_int    <= 1'b0;
    end else begin
      carga_int <= sel_carga;
      j1_int    <= sel_j1 & lib_j1;
      j2_int    <= sel_j2 & lib_j2;
    end
  end

endmodule

// File: tb/tb_botoes_condicionador.sv
// tb_botoes_condicionador: bench for botoes_condicionador with DEBOUNCE_CYCLES = 4.
// - A reference model predicts debounced levels and strobe cycles.
// - Predicted strobes go into exp_q.
// - A monitor on the falling edge pops exp_q and compares against the DUT.
module tb_botoes_condicionador;

  localparam int D = 4;
  localparam int W = 32;

`ifdef BOTOES_TURN_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic       btn_carga = 1'b0;
  logic       btn_j1    = 1'b0;
  logic       btn_j2    = 1'b0;
  logic       carga_int;
  logic       j1_int;
  logic       j2_int;
  logic [2:0] btn_nivel;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [2:0] m_level  = 3'b000;
  logic [W-1:0] exp_q[$];

  botoes_condicionador #(.DEBOUNCE_CYCLES(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_carga (btn_carga),
    .btn_j1    (btn_j1),
    .btn_j2    (btn_j2),
    .carga_int (carga_int),
    .j1_int    (j1_int),
    .j2_int    (j2_int),
    .btn_nivel (btn_nivel)
  );

  // Clock generation.
  always #5 clock = ~clock;

  // Reference model, evaluated at every rising edge.
  // - The logic sees each raw sample two clocks later.
  // - A debounced level flips once D+1 consecutive seen samples disagree with it.
  // - A rise becomes a strobe on the following edge, after priority and turn rules.
  initial begin : model
    logic [2:0] raw;
    logic [2:0] seen1;
    logic [2:0] seen2;
    logic [2:0] pend;
    logic [2:0] rise;
    logic [2:0] win;
    int         run [3];
    int         tok;
    seen1 = 3'b000;
    seen2 = 3'b000;
    pend  = 3'b000;
    tok   = 0;
    for (int i = 0; i < 3; i++) run[i] = 0;
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
      raw = {btn_carga, btn_j2, btn_j1};
      if (reset) begin
        seen1   = 3'b000;
        seen2   = 3'b000;
        pend    = 3'b000;
        m_level = 3'b000;
        tok     = 0;
        for (int i = 0; i < 3; i++) run[i] = 0;
      end else begin
        win = 3'b000;
        if (pend[2]) begin
          win = 3'b100;
          tok = 0;
        end else if (pend[0]) begin
          if (!LOCKOUT || tok != 1) begin
            win = 3'b001;
            tok = 1;
          end
        end else if (pend[1]) begin
          if (!LOCKOUT || tok != 2) begin
            win = 3'b010;
            tok = 2;
          end
        end
        if (win != 3'b000) exp_q.push_back({cyc[W-4:0], win});
        rise = 3'b000;
        for (int i = 0; i < 3; i++) begin
          if (seen2[i] != m_level[i]) run[i] = run[i] + 1;
          else run[i] = 0;
          if (run[i] == D + 1) begin
            m_level[i] = seen2[i];
            run[i]     = 0;
            if (seen2[i]) rise[i] = 1'b1;
          end
        end
        pend  = rise;
        seen2 = seen1;
        seen1 = raw;
      end
    end
  end

  // Monitor: checks levels, strobe exclusivity and strobes against the scoreboard.
  initial begin : monitor
    logic [2:0]   got;
    logic [W-1:0] head;
    int           hc;
    forever begin
      @(negedge clock);
      got = {carga_int, j2_int, j1_int};
      n_checks = n_checks + 1;
      if (btn_nivel !== m_level) begin
        n_fail = n_fail + 1;
        $display("FAIL btn_nivel cyc=%0d got=%b exp=%b", cyc, btn_nivel, m_level);
      end
      n_checks = n_checks + 1;
      if ($countones(got) > 1) begin
        n_fail = n_fail + 1;
        $display("FAIL one_hot cyc=%0d got={carga,j2,j1}=%b exp=at most one set", cyc, got);
      end
      while (exp_q.size() > 0) begin
        head = exp_q[0];
        hc   = int'(head[W-1:3]);
        if (hc >= cyc) break;
        n_checks = n_checks + 1;
        n_fail   = n_fail + 1;
        $display("FAIL pulse_missing cyc=%0d got=none exp={carga,j2,j1}=%b at cyc=%0d",
                 cyc, head[2:0], hc);
        void'(exp_q.pop_front());
      end
      if (got != 3'b000) begin
        n_checks = n_checks + 1;
        hc = -1;
        if (exp_q.size() > 0) begin
          head = exp_q[0];
          hc   = int'(head[W-1:3]);
        end
        if (hc == cyc) begin
          void'(exp_q.pop_front());
          if (head[2:0] !== got) begin
            n_fail = n_fail + 1;
            $display("FAIL pulse_kind cyc=%0d got={carga,j2,j1}=%b exp=%b", cyc, got, head[2:0]);
          end
        end else begin
          n_fail = n_fail + 1;
          $display("FAIL pulse_unexpected cyc=%0d got={carga,j2,j1}=%b exp=none", cyc, got);
        end
      end
    end
  end

  // Driver: apply button levels {carga, j2, j1} at a falling edge and hold for n clocks.
  task automatic drive(input logic [2:0] v, input int n);
    btn_carga = v[2];
    btn_j2    = v[1];
    btn_j1    = v[0];
    repeat (n) @(negedge clock);
  endtask

  // Driver: hold reset high for n clocks, then release it.
  task automatic pulse_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  // Stimulus: directed scenarios first, then random bouncing with occasional resets.
  initial begin : stim
    @(negedge clock);
    pulse_reset(3);
    // Clean j1 press, held well past debounce.
    drive(3'b001, 20);
    drive(3'b000, 12);
    // j2 glitch (3 high, 2 low) followed by a held press.
    drive(3'b010, 3);
    drive(3'b000, 2);
    drive(3'b010, 15);
    drive(3'b000, 12);
    // carga and j1 rising on the same edge.
    drive(3'b101, 15);
    drive(3'b000, 12);
    // j1 held across a 2-clock reset in the middle of its debounce.
    drive(3'b001, 3);
    pulse_reset(2);
    drive(3'b001, 15);
    drive(3'b000, 12);
    // Sequence j1, j1, j2 for the turn rule.
    drive(3'b001, 12);
    drive(3'b000, 12);
    drive(3'b001, 12);
    drive(3'b000, 12);
    drive(3'b010, 12);
    drive(3'b000, 12);
    // Short pulses just below and at the debounce length.
    drive(3'b100, D);
    drive(3'b000, 10);
    drive(3'b100, D + 1);
    drive(3'b000, 12);
    // Random bouncing on all three buttons.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 40) == 0) pulse_reset($urandom_range(1, 3));
      drive(3'($urandom_range(0, 7)), $urandom_range(1, 12));
    end
    drive(3'b000, 20);
    #1;
    n_checks = n_checks + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain got=%0d pending strobes exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/botoes_condicionador.md
BOTOES_CONDICIONADOR -- requirements
Module: botoes_condicionador

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive clocks a synchronized input must hold a new level before it is accepted (20 ms at 50 MHz).
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port btn_carga  input  1  raw, asynchronous, bouncing load/start push-button.
REQ-005 SHALL have port btn_j1  input  1  raw, asynchronous player-1 push-button.
REQ-006 SHALL have port btn_j2  input  1  raw, asynchronous player-2 push-button.
REQ-007 SHALL have port carga_int  output  1  registered one-clock pulse per accepted carga press.
REQ-008 SHALL have port j1_int  output  1  registered one-clock pulse per accepted player-1 press.
REQ-009 SHALL have port j2_int  output  1  registered one-clock pulse per accepted player-2 press.
REQ-010 SHALL have port btn_nivel  output  3  debounced levels {carga, j2, j1}, bit 0 = j1.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each channel SHALL run an independent FSM: SOLTO -> CONF_PRESS (sync=1) -> PRESSIONADO (held DEBOUNCE_CYCLES) -> CONF_SOLTO (sync=0) -> SOLTO (held DEBOUNCE_CYCLES).
REQ-013 In CONF_PRESS/CONF_SOLTO any sample contrary to the target level SHALL clear the channel counter and return to the previous stable state.
REQ-014 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)); it SHALL saturate, never wrap.
REQ-015 Debounced level SHALL change on edge 2+DEBOUNCE_CYCLES after the raw level is first sampled, if held stable throughout.
REQ-016 A raw pulse shorter than DEBOUNCE_CYCLES clocks SHALL produce no level change and no pulse.
REQ-017 Candidate pulse SHALL be raised only on SOLTO/CONF_PRESS -> PRESSIONADO, registered, visible one clock after the level rise (edge DEBOUNCE_CYCLES+3); release SHALL produce no pulse.
REQ-018 Each output pulse SHALL be high exactly one clock; a held button SHALL never re-pulse.
REQ-019 Arbitration same cycle: carga candidate SHALL suppress j1/j2 candidates; j1 candidate SHALL suppress j2 candidate; suppressed candidates SHALL be discarded, not deferred.
REQ-020 At most one of carga_int, j1_int, j2_int SHALL be high in any cycle.

Reset
REQ-021 With reset high at a rising edge: synchronizers, counters, btn_nivel, carga_int, j1_int, j2_int SHALL be 0 and all FSMs SOLTO, next cycle.
REQ-022 Reset mid-debounce SHALL discard the partial count; a button held through reset release SHALL be re-debounced from zero and SHALL pulse once.

Configuration
REQ-023 Macro BOTOES_TURN_LOCKOUT_EN defined: a turn token SHALL block repeated j1_int until j2_int or carga_int is issued, and repeated j2_int until j1_int or carga_int; token cleared (both allowed) at reset and on carga_int; blocked candidates discarded.
REQ-024 Macro BOTOES_TURN_LOCKOUT_EN undefined: no token logic; every accepted press SHALL pulse per REQ-019.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 btn_j1 0->1 clean at edge 10, held -> btn_nivel[0]=1 after edge 16, j1_int=1 only during cycle after edge 17, never again while held.
REQ-026 btn_j2 glitches 1 for 3 clocks, 0 for 2, then 1 held -> single j2_int, 4+3 clocks after final rise; no pulse from glitch.
REQ-027 btn_carga and btn_j1 rise on the same edge, both held -> carga_int pulses once, j1_int never pulses.
REQ-028 btn_j1 held, reset asserted 2 clocks mid-debounce then released -> outputs 0 during reset; one j1_int at edge DEBOUNCE_CYCLES+3 counted from reset release.
REQ-029 BOTOES_TURN_LOCKOUT_EN defined: j1 press, j1 press, j2 press -> j1_int, none, j2_int; undefined: j1_int, j1_int, j2_int.
